// File: rtl/cordic_sign_sequencer_if.sv
// Handshake/status bundle between the hyperbolic CORDIC datapath (master)
// and the iteration/sign sequencer (slave).
interface cordic_sign_sequencer_if #(
  parameter int ITER_WIDTH = 5
);
  logic                  start;
  logic                  sign_x;
  logic                  sign_y;
  logic                  sign_z;
  logic                  busy;
  logic                  iter_valid;
  logic [ITER_WIDTH-1:0] iter_idx;
  logic                  dir;
  logic                  done;
  logic                  sign_result;

  // datapath side: requests a run and feeds back live register signs
  modport master (
    output start, sign_x, sign_y, sign_z,
    input  busy, iter_valid, iter_idx, dir, done, sign_result
  );

  // sequencer side
  modport slave (
    input  start, sign_x, sign_y, sign_z,
    output busy, iter_valid, iter_idx, dir, done, sign_result
  );
endinterface

// File: rtl/cordic_sign_sequencer.sv
// Iteration sequencer for the natural-log hyperbolic-vectoring CORDIC.
// Walks indices 1..ITERATIONS, repeating 4 and 13 once each so the
// hyperbolic series converges, drives the per-iteration direction from the
// live X/Y signs and latches the Z sign as the result sign on the last step.
module cordic_sign_sequencer #(
  parameter int ITERATIONS = 16,
  parameter int ITER_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  cordic_sign_sequencer_if.slave  bus
);

  localparam int                    MAX_IDX = (1 << ITER_WIDTH) - 1;
  localparam logic [ITER_WIDTH-1:0] LAST    = ITER_WIDTH'(ITERATIONS);
  localparam logic [ITER_WIDTH-1:0] REP_A   = ITER_WIDTH'(4);
  localparam logic [ITER_WIDTH-1:0] REP_B   = ITER_WIDTH'(13);
  localparam logic [ITER_WIDTH-1:0] FIRST   = ITER_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ITER_WIDTH-1:0] idx, idx_nxt;
  logic                  rep_flag, rep_nxt;
  logic                  res, res_nxt;
  logic                  rep_hit;

  // Repeat indices are checked before the end-of-run test so that a run
  // ending exactly on 4 or 13 still performs the repeat.
  assign rep_hit = ((idx == REP_A) || (idx == REP_B)) && !rep_flag &&
                   (int'(idx) <= ITERATIONS);

  // State, index, repeat marker and result sign registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      rep_flag <= 1'b0;
      res      <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      rep_flag <= rep_nxt;
      res      <= res_nxt;
    end
  end

  // Next-state: START only matters in IDLE; FINISH always returns to IDLE
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rep_nxt   = rep_flag;
    res_nxt   = res;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ITER;
          idx_nxt   = FIRST;
          rep_nxt   = 1'b0;
        end
      end
      ITER: begin
        if (rep_hit) begin
          rep_nxt = 1'b1;
        end else if (idx == LAST) begin
          state_nxt = FINISH;
          idx_nxt   = '0;
          rep_nxt   = 1'b0;
          res_nxt   = bus.sign_z;
        end else begin
          idx_nxt = idx + FIRST;
          rep_nxt = 1'b0;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        rep_nxt   = 1'b0;
      end
    endcase
  end

  // Status outputs decode straight from the registered state; DIR is the
  // only combinational path (d_i = -sign(x*y)), gated off outside ITER.
  assign bus.busy        = (state != IDLE);
  assign bus.iter_valid  = (state == ITER);
  assign bus.done        = (state == FINISH);
  assign bus.iter_idx    = idx;
  assign bus.sign_result = res;
  assign bus.dir         = (state == ITER) & ~(bus.sign_x ^ bus.sign_y);

`ifndef SYNTHESIS
  // The index counter must be able to hold the last iteration without wrap
  always_ff @(posedge clk) begin
    assert (ITERATIONS >= 1 && ITERATIONS <= MAX_IDX)
      else $error("cordic_sign_sequencer: ITERATIONS=%0d does not fit ITER_WIDTH=%0d",
                  ITERATIONS, ITER_WIDTH);
  end
`endif

endmodule

// File: tb/tb_cordic_sign_sequencer.sv
// Directed bench for cordic_sign_sequencer: default 16-iteration instance
// plus a short 3-iteration instance sharing clock and reset.
module tb_cordic_sign_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cordic_sign_sequencer_if #(.ITER_WIDTH(5)) bus ();
  cordic_sign_sequencer_if #(.ITER_WIDTH(5)) bus3 ();

  cordic_sign_sequencer #(.ITERATIONS(16), .ITER_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  cordic_sign_sequencer #(.ITERATIONS(3), .ITER_WIDTH(5)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  // hand-derived index sequence for ITERATIONS=16 (4 and 13 repeated)
  int exp_idx [18] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16};
  // DIR for (sx,sy) = 00,01,10,11
  int dir_tab [4]  = '{1, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse (or hold) START from IDLE; returns in the first ITER cycle
  task automatic start_run(input bit hold);
    bus.start = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
  endtask

  // Walks the 18 ITER cycles; abort_idx != 0 applies reset at that index
  task automatic iter_phase(input bit zlast, input int abort_idx);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("iter_valid[%0d]", k), bus.iter_valid, 1);
      chk($sformatf("busy[%0d]", k), bus.busy, 1);
      chk($sformatf("iter_idx[%0d]", k), bus.iter_idx, exp_idx[k]);
      chk($sformatf("done_low[%0d]", k), bus.done, 0);
      bus.sign_x = k[1];
      bus.sign_y = k[0];
      bus.sign_z = (k == 17) ? zlast : ~zlast;
      #1;
      chk($sformatf("dir[%0d]", k), bus.dir, dir_tab[k % 4]);
      if (abort_idx != 0 && exp_idx[k] == abort_idx) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.iter_valid, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_idx", bus.iter_idx, 0);
        chk("abort_sres", bus.sign_result, 0);
        for (int j = 0; j < 3; j++) begin
          step();
          chk("abort_no_done", bus.done, 0);
          chk("abort_stay_idle", bus.busy, 0);
        end
        return;
      end
      step();
    end
    bus.sign_z = ~zlast;
    chk("fin_done", bus.done, 1);
    chk("fin_busy", bus.busy, 1);
    chk("fin_valid", bus.iter_valid, 0);
    chk("fin_idx", bus.iter_idx, 0);
    chk("fin_sres", bus.sign_result, zlast);
    step();
    chk("post_busy", bus.busy, 0);
    chk("post_done", bus.done, 0);
    chk("post_sres", bus.sign_result, zlast);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start  = 1'b1;  bus.sign_x  = 1'b0; bus.sign_y  = 1'b0; bus.sign_z  = 1'b0;
    bus3.start = 1'b1;  bus3.sign_x = 1'b0; bus3.sign_y = 1'b0; bus3.sign_z = 1'b0;

    // reset held two cycles with START asserted
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.iter_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sres", bus.sign_result, 0);
    chk("rst_idx", bus.iter_idx, 0);
    rst = 1'b0;
    bus.start  = 1'b0;
    bus3.start = 1'b0;
    step();
    chk("idle_busy", bus.busy, 0);

    // run 1: result sign 1, held through IDLE
    start_run(1'b0);
    iter_phase(1'b1, 0);
    repeat (3) step();
    chk("hold_sres", bus.sign_result, 1);
    chk("hold_busy", bus.busy, 0);

    // run 2: result sign 0
    start_run(1'b0);
    iter_phase(1'b0, 0);

    // START held through a whole run: ignored while busy and in FINISH,
    // accepted in the first IDLE cycle after DONE
    start_run(1'b1);
    iter_phase(1'b1, 0);
    chk("b2b_idle_valid", bus.iter_valid, 0);
    step();
    bus.start = 1'b0;
    chk("b2b_restart_valid", bus.iter_valid, 1);
    chk("b2b_restart_idx", bus.iter_idx, 1);

    // that back-to-back run is reset at index 7
    iter_phase(1'b0, 7);

    // a fresh START after reset restarts at index 1 and completes
    start_run(1'b0);
    iter_phase(1'b1, 0);

    // ITERATIONS=3 instance: 1,2,3 with no repeats, then DONE
    bus3.start = 1'b1;
    step();
    bus3.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("it3_valid[%0d]", k), bus3.iter_valid, 1);
      chk($sformatf("it3_idx[%0d]", k), bus3.iter_idx, k);
      bus3.sign_z = (k == 3);
      step();
    end
    bus3.sign_z = 1'b0;
    chk("it3_done", bus3.done, 1);
    chk("it3_valid_fin", bus3.iter_valid, 0);
    chk("it3_sres", bus3.sign_result, 1);
    step();
    chk("it3_idle", bus3.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
